// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Stepped-chirp controller placed directly in front of a DDS core. A start
// pulse latches the sweep configuration and then walks the frequency word
// from f_start to f_stop in f_step increments, holding every point for
// max(dwell,1) clock cycles. Single-shot and auto-restart (continuous)
// sweeps are supported; abort returns the block to IDLE at once.
//
// Optional feature (compile-time macro):
//   DDS_SWEEP_TRIANGLE_EN - after reaching f_stop the sweep walks back down
//                           to f_start before the pass ends (triangle shape).
//                           Undefined: sawtooth sweep only.
//
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   start        - single-cycle sweep request, ignored while busy
//   abort        - stop sweeping immediately (highest priority)
//   mode_cont    - 1 = restart at f_start after every pass (latched at start)
//   f_start      - first frequency word (latched at start)
//   f_stop       - final frequency word, unsigned (latched at start)
//   f_step       - increment per step, unsigned (latched at start)
//   dwell        - cycles per frequency point, 0 acts as 1 (latched at start)
//   pword_in     - phase offset, forwarded with one cycle of latency
//   dds_en       - DDS enable
//   fword        - DDS frequency control word
//   pword        - DDS phase control word
//   busy         - sweep in progress
//   step_tick    - one-cycle pulse whenever fword takes a new value
//   sweep_done   - one-cycle pulse in the first cycle after each pass
// All outputs are registered.
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int FW_W = 32,
    parameter int PW_W = 12,
    parameter int DW_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            mode_cont,
    input  logic [FW_W-1:0] f_start,
    input  logic [FW_W-1:0] f_stop,
    input  logic [FW_W-1:0] f_step,
    input  logic [DW_W-1:0] dwell,
    input  logic [PW_W-1:0] pword_in,
    output logic            dds_en,
    output logic [FW_W-1:0] fword,
    output logic [PW_W-1:0] pword,
    output logic            busy,
    output logic            step_tick,
    output logic            sweep_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1
`ifdef DDS_SWEEP_TRIANGLE_EN
        ,
        ST_DOWN = 2'd2
`endif
    } state_e;

    state_e          state_q;
    logic            dds_en_q;
    logic [FW_W-1:0] fword_q;
    logic [PW_W-1:0] pword_q;
    logic            busy_q;
    logic            step_tick_q;
    logic            sweep_done_q;
    logic [DW_W-1:0] dwell_cnt_q;

    // Configuration captured at start; mid-sweep input changes are ignored.
    logic            cont_q;
    logic [FW_W-1:0] f_start_q;
    logic [FW_W-1:0] f_stop_q;
    logic [FW_W-1:0] f_step_q;
    logic [DW_W-1:0] dwell_q;

    // Last dwell count of a point: dwell of 0 is handled like dwell of 1.
    logic [DW_W-1:0] dwell_last_d;
    logic            dwell_end_d;
    assign dwell_last_d = (dwell_q == '0) ? '0 : dwell_q - DW_W'(1);
    assign dwell_end_d  = (dwell_cnt_q == dwell_last_d);

    // Upward step computed one bit wider so a carry out clamps to f_stop
    // instead of wrapping around to a low frequency.
    logic [FW_W:0]   up_sum_d;
    logic            up_clamp_d;
    logic [FW_W-1:0] up_next_d;
    logic            up_end_d;
    assign up_sum_d   = {1'b0, fword_q} + {1'b0, f_step_q};
    assign up_clamp_d = up_sum_d[FW_W] || (up_sum_d[FW_W-1:0] > f_stop_q);
    assign up_next_d  = up_clamp_d ? f_stop_q : up_sum_d[FW_W-1:0];
    assign up_end_d   = (fword_q >= f_stop_q) || (f_step_q == '0);

    logic pass_end_d;

`ifdef DDS_SWEEP_TRIANGLE_EN
    // Downward step mirrors the upward one: a borrow clamps to f_start.
    logic [FW_W:0]   dn_diff_d;
    logic            dn_clamp_d;
    logic [FW_W-1:0] dn_next_d;
    logic            dn_end_d;
    logic            has_down_d;
    assign dn_diff_d  = {1'b0, fword_q} - {1'b0, f_step_q};
    assign dn_clamp_d = dn_diff_d[FW_W] || (dn_diff_d[FW_W-1:0] < f_start_q);
    assign dn_next_d  = dn_clamp_d ? f_start_q : dn_diff_d[FW_W-1:0];
    assign dn_end_d   = (fword_q <= f_start_q);
    // A flat or reversed range has nothing to walk back down.
    assign has_down_d = (f_step_q != '0) && (f_start_q < f_stop_q);

    assign pass_end_d = dwell_end_d &&
                        (((state_q == ST_UP) && up_end_d && !has_down_d) ||
                         ((state_q == ST_DOWN) && dn_end_d));
`else
    assign pass_end_d = dwell_end_d && (state_q == ST_UP) && up_end_d;
`endif

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register in this block samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched configuration is reset too; it is a handful
            // of flops, not a memory, and keeps the comparators X-free.
            state_q      <= ST_IDLE;
            dds_en_q     <= 1'b0;
            fword_q      <= '0;
            pword_q      <= '0;
            busy_q       <= 1'b0;
            step_tick_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            dwell_cnt_q  <= '0;
            cont_q       <= 1'b0;
            f_start_q    <= '0;
            f_stop_q     <= '0;
            f_step_q     <= '0;
            dwell_q      <= '0;
        end else begin
            pword_q      <= pword_in;
            step_tick_q  <= 1'b0;
            sweep_done_q <= 1'b0;

            if (abort) begin
                state_q     <= ST_IDLE;
                dds_en_q    <= 1'b0;
                busy_q      <= 1'b0;
                fword_q     <= '0;
                dwell_cnt_q <= '0;
            end else if (pass_end_d) begin
                sweep_done_q <= 1'b1;
                dwell_cnt_q  <= '0;
                if (cont_q) begin
                    state_q     <= ST_UP;
                    fword_q     <= f_start_q;
                    step_tick_q <= 1'b1;
                end else begin
                    state_q  <= ST_IDLE;
                    dds_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    fword_q  <= '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            cont_q      <= mode_cont;
                            f_start_q   <= f_start;
                            f_stop_q    <= f_stop;
                            f_step_q    <= f_step;
                            dwell_q     <= dwell;
                            fword_q     <= f_start;
                            dds_en_q    <= 1'b1;
                            busy_q      <= 1'b1;
                            step_tick_q <= 1'b1;
                            dwell_cnt_q <= '0;
                            state_q     <= ST_UP;
                        end
                    end
                    ST_UP: begin
                        if (!dwell_end_d) begin
                            dwell_cnt_q <= dwell_cnt_q + DW_W'(1);
                        end else begin
                            dwell_cnt_q <= '0;
                            step_tick_q <= 1'b1;
`ifdef DDS_SWEEP_TRIANGLE_EN
                            // The stop point was just held for its dwell, so
                            // the turnaround steps down immediately.
                            if (up_end_d) begin
                                state_q <= ST_DOWN;
                                fword_q <= dn_next_d;
                            end else
`endif
                            begin
                                fword_q <= up_next_d;
                            end
                        end
                    end
`ifdef DDS_SWEEP_TRIANGLE_EN
                    ST_DOWN: begin
                        if (!dwell_end_d) begin
                            dwell_cnt_q <= dwell_cnt_q + DW_W'(1);
                        end else begin
                            dwell_cnt_q <= '0;
                            step_tick_q <= 1'b1;
                            fword_q     <= dn_next_d;
                        end
                    end
`endif
                    default: begin
                        state_q     <= ST_IDLE;
                        dds_en_q    <= 1'b0;
                        busy_q      <= 1'b0;
                        fword_q     <= '0;
                        dwell_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign dds_en     = dds_en_q;
    assign fword      = fword_q;
    assign pword      = pword_q;
    assign busy       = busy_q;
    assign step_tick  = step_tick_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Directed plus randomized bench for dds_sweep_ctrl. The reference model
// builds the list of frequency points for a sweep with plain arithmetic and
// expands it into the expected per-cycle output trace (each point held
// max(dwell,1) cycles, step_tick on the first cycle of a point, sweep_done
// in the cycle after the last point). Compile with DDS_SWEEP_TRIANGLE_EN to
// check the triangle build; the model follows the same macro.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    localparam int FW_W = 32;
    localparam int PW_W = 12;
    localparam int DW_W = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic            mode_cont;
    logic [FW_W-1:0] f_start;
    logic [FW_W-1:0] f_stop;
    logic [FW_W-1:0] f_step;
    logic [DW_W-1:0] dwell;
    logic [PW_W-1:0] pword_in;
    logic            dds_en;
    logic [FW_W-1:0] fword;
    logic [PW_W-1:0] pword;
    logic            busy;
    logic            step_tick;
    logic            sweep_done;

    int              checks   = 0;
    int              failures = 0;
    logic [PW_W-1:0] pw_last;
    longint          pts[$];

    dds_sweep_ctrl #(.FW_W(FW_W), .PW_W(PW_W), .DW_W(DW_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mode_cont  (mode_cont),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .pword_in   (pword_in),
        .dds_en     (dds_en),
        .fword      (fword),
        .pword      (pword),
        .busy       (busy),
        .step_tick  (step_tick),
        .sweep_done (sweep_done)
    );

    always #10 clk = ~clk;  // 50 MHz

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // New inputs after an edge: quiet (start/abort low) or scrambled to show
    // that a running sweep ignores start and live configuration changes.
    task automatic drive(input bit scr);
        abort = 1'b0;
        if (scr) begin
            start     = 1'($urandom_range(0, 1));
            mode_cont = 1'($urandom_range(0, 1));
            f_start   = $urandom;
            f_stop    = $urandom;
            f_step    = $urandom;
            dwell     = 16'($urandom);
        end else begin
            start = 1'b0;
        end
        pw_last  = 12'($urandom);
        pword_in = pw_last;
    endtask

    // Advance one clock; pword must show the value driven before the edge.
    task automatic tick(input bit scr);
        @(posedge clk);
        #1;
        check("pword", {52'd0, pword}, {52'd0, pw_last});
        drive(scr);
    endtask

    task automatic expect_out(input string tag, input bit en, input longint fw,
                              input bit bs, input bit tk, input bit dn);
        check({tag, ".dds_en"}, {63'd0, dds_en}, {63'd0, en});
        check({tag, ".fword"}, {32'd0, fword}, fw);
        check({tag, ".busy"}, {63'd0, busy}, {63'd0, bs});
        check({tag, ".step_tick"}, {63'd0, step_tick}, {63'd0, tk});
        check({tag, ".sweep_done"}, {63'd0, sweep_done}, {63'd0, dn});
    endtask

    // Frequency points of one pass, from the sweep rules.
    task automatic build_points(input longint fs, input longint fe, input longint st);
        longint cur;
        pts.delete();
        cur = fs;
        pts.push_back(cur);
        if (st != 0) begin
            while (cur < fe) begin
                cur = cur + st;
                if (cur > fe) cur = fe;
                pts.push_back(cur);
            end
        end
`ifdef DDS_SWEEP_TRIANGLE_EN
        if (st != 0 && fs < fe) begin
            while (cur > fs) begin
                cur = cur - st;
                if (cur < fs) cur = fs;
                pts.push_back(cur);
            end
        end
`endif
    endtask

    // Launch a sweep and check the full trace for the given number of passes.
    // Single mode ends after the idle cycle; continuous mode returns while
    // sitting in the first cycle of the following pass.
    task automatic run_sweep(input string tag, input longint fs, input longint fe,
                             input longint st, input int dw, input bit cont,
                             input int passes, input bit scr);
        int d_len;
        bit last;
        d_len = (dw == 0) ? 1 : dw;
        build_points(fs, fe, st);
        f_start   = fs[31:0];
        f_stop    = fe[31:0];
        f_step    = st[31:0];
        dwell     = dw[15:0];
        mode_cont = cont;
        abort     = 1'b0;
        start     = 1'b1;
        tick(scr);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < pts.size(); i++) begin
                for (int d = 0; d < d_len; d++) begin
                    expect_out($sformatf("%s.p%0d.pt%0d.c%0d", tag, p, i, d),
                               1'b1, pts[i], 1'b1, d == 0, (p > 0) && (i == 0) && (d == 0));
                    last = (p == passes - 1) && (i == pts.size() - 1) && (d == d_len - 1);
                    tick(last ? 1'b0 : scr);
                end
            end
        end
        if (!cont) begin
            expect_out({tag, ".done"}, 1'b0, 0, 1'b0, 1'b0, 1'b1);
            tick(1'b0);
            expect_out({tag, ".idle"}, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end else begin
            expect_out({tag, ".restart"}, 1'b1, fs, 1'b1, 1'b1, 1'b1);
        end
    endtask

    initial begin
        longint fs, fe, st;
        int     sel;

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        mode_cont = 1'b0;
        f_start   = '0;
        f_stop    = '0;
        f_step    = '0;
        dwell     = '0;
        pw_last   = 12'hA5C;
        pword_in  = pw_last;

        // Reset state, including pword held at 0 despite a live pword_in.
        #15;
        expect_out("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("reset.pword", {52'd0, pword}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0);
        expect_out("post_reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Directed configurations.
        run_sweep("single", 100, 400, 100, 3, 1'b0, 1, 1'b0);
        run_sweep("clamp", 0, 250, 100, 1, 1'b0, 1, 1'b0);
        run_sweep("ovf", 64'hFFFF_FF00, 64'hFFFF_FFFF, 64'h200, 2, 1'b0, 1, 1'b0);
        run_sweep("dwell0", 10, 30, 10, 0, 1'b0, 1, 1'b0);
        run_sweep("step0", 700, 900, 0, 2, 1'b0, 1, 1'b0);
        run_sweep("reverse", 500, 100, 50, 2, 1'b0, 1, 1'b0);
        run_sweep("tri", 100, 300, 100, 2, 1'b0, 1, 1'b0);

        // Continuous sweep, ignored start while busy, then abort mid-point.
        run_sweep("cont", 100, 300, 100, 2, 1'b1, 2, 1'b0);
        f_start = 32'd7;
        f_stop  = 32'd9;
        start   = 1'b1;
        tick(1'b0);
        expect_out("cont.busy_start", 1'b1, 100, 1'b1, 1'b0, 1'b0);
        tick(1'b0);
        expect_out("cont.pt1", 1'b1, 200, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick(1'b0);
        expect_out("abort", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick(1'b0);
        expect_out("abort.idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // abort together with start in IDLE keeps the block idle.
        start = 1'b1;
        abort = 1'b1;
        tick(1'b0);
        expect_out("abort_start", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick(1'b0);
        expect_out("abort_start.idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset during the second point.
        f_start   = 32'd100;
        f_stop    = 32'd400;
        f_step    = 32'd100;
        dwell     = 16'd3;
        mode_cont = 1'b0;
        start     = 1'b1;
        tick(1'b0);
        expect_out("rst_mid.pt0", 1'b1, 100, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0);
        expect_out("rst_mid.pt1", 1'b1, 200, 1'b1, 1'b1, 1'b0);
        #4;
        rst_n = 1'b0;
        #1;
        expect_out("rst_mid.async", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("rst_mid.pword", {52'd0, pword}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            expect_out($sformatf("rst_mid.idle%0d", k), 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end

        // Randomized sweeps with scrambled inputs while busy.
        for (int n = 0; n < 12; n++) begin
            sel = $urandom_range(0, 4);
            fs  = longint'($urandom_range(32'hFFFF_0000, 0));
            if (sel == 0) begin
                st = 0;
                fe = fs + longint'($urandom_range(5000, 0));
            end else if (sel == 1) begin
                st = longint'($urandom_range(1500, 300));
                fe = fs / 2;
            end else begin
                st = longint'($urandom_range(1500, 300));
                fe = fs + longint'($urandom_range(5000, 0));
            end
            if (sel == 4) begin
                run_sweep($sformatf("rnd%0d", n), fs, fe, st,
                          int'($urandom_range(4, 0)), 1'b1, 2, 1'b1);
                abort = 1'b1;
                tick(1'b0);
                expect_out($sformatf("rnd%0d.abort", n), 1'b0, 0, 1'b0, 1'b0, 1'b0);
            end else begin
                run_sweep($sformatf("rnd%0d", n), fs, fe, st,
                          int'($urandom_range(4, 0)), 1'b0, 1, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep controller that sits directly upstream of the DDS core and drives its enable, frequency-control-word and phase-control-word inputs. On a start pulse it steps the frequency word linearly from a start value to a stop value, holding each value for a programmable number of clock cycles. It supports single-shot and continuous (auto-restart) sweeps. The result is a stepped chirp at the DDS output without software involvement.

## Interface
Parameters:
- FW_W, 32, frequency word width (matches DDS phase accumulator)
- PW_W, 12, phase word width
- DW_W, 16, dwell counter width

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle sweep request; ignored while busy
- abort  in  1  stop sweep immediately
- mode_cont  in  1  1 = restart at f_start after each sweep; latched at start
- f_start  in  FW_W  first frequency word; latched at start
- f_stop  in  FW_W  final frequency word, unsigned; latched at start
- f_step  in  FW_W  increment per step, unsigned; latched at start
- dwell  in  DW_W  cycles per frequency point; 0 is treated as 1; latched at start
- pword_in  in  PW_W  phase offset
- dds_en  out  1  DDS enable
- fword  out  FW_W  DDS frequency word
- pword  out  PW_W  DDS phase word
- busy  out  1  sweep in progress
- step_tick  out  1  one-cycle pulse whenever fword takes a new value
- sweep_done  out  1  one-cycle pulse at end of each sweep pass

## Operation
- States: IDLE, UP, DOWN. DOWN exists only with the macro enabled.
- IDLE:
  - dds_en=0, busy=0, fword=0.
  - start=1 and abort=0: latch config, fword<=f_start, dds_en<=1, busy<=1, step_tick<=1, dwell_cnt<=0, go to UP.
- UP:
  - dwell_cnt increments each cycle.
  - At dwell_cnt==max(dwell,1)-1, dwell_cnt<=0 and the sweep either ends or steps.
  - End of pass when fword>=f_stop or f_step==0.
  - Otherwise step: next = fword+f_step computed at FW_W+1 bits. If the carry is set or next>f_stop, fword<=f_stop; else fword<=next. Pulse step_tick.
- End of pass:
  - Pulse sweep_done.
  - If mode_cont: fword<=f_start, step_tick pulse, stay busy, re-enter UP.
  - Else: go to IDLE, dds_en<=0, busy<=0, fword<=0.
- f_start>f_stop: a single dwell at f_start, then end of pass.
- abort (any state, highest priority): next cycle IDLE, dds_en=0, busy=0, fword=0, no sweep_done. abort together with start in IDLE: stays IDLE.
- start while busy: ignored. Input changes mid-sweep have no effect; only the latched config is used.
- pword: registered copy of pword_in every cycle, independent of state.

## Timing
- Reset values: dds_en=0, fword=0, pword=0, busy=0, step_tick=0, sweep_done=0, state IDLE, dwell_cnt=0.
- All outputs are registered.
- start sampled high at edge k gives fword=f_start, dds_en=1, busy=1 from edge k+1.
- Each frequency point is held exactly D=max(dwell,1) cycles.
- Single sweep with N points: busy high for N*D cycles.
- sweep_done is high in the first cycle after the last point, together with dds_en=0 (single) or fword=f_start (continuous).
- pword latency: 1 cycle.
- The DDS adds its own 2-cycle latency downstream; this block does not compensate for it.

## Configuration
- DDS_SWEEP_TRIANGLE_EN defined:
  - On reaching end of pass in UP, sweep_done is not pulsed. State goes to DOWN.
  - DOWN mirrors UP: next = fword-f_step with borrow check, clamped to f_start, each point held D cycles.
  - End of pass in DOWN is fword<=f_start. It triggers sweep_done and the restart/IDLE rules above.
  - The stop point is held for one dwell only, not two.
  - f_step==0 or f_start>=f_stop: no DOWN phase.
- Not defined: DOWN is absent, sawtooth only.

## Test plan
- Single sweep: f_start=100, f_stop=400, f_step=100, dwell=3, start pulse → fword 100,200,300,400, each for 3 cycles. 4 step_ticks. sweep_done and dds_en=0 on cycle 13 after start.
- Clamp and overflow:
  - f_start=0, f_stop=250, f_step=100, dwell=1 → 0,100,200,250, done.
  - f_start=0xFFFFFF00, f_stop=0xFFFFFFFF, f_step=0x200 → 0xFFFFFF00, 0xFFFFFFFF (no wrap).
- Edge configs:
  - dwell=0 behaves as dwell=1.
  - f_step=0 → one point at f_start, then done.
  - f_start=500 > f_stop=100 → one point, done.
- Continuous plus abort: mode_cont=1, 100→300 step 100 dwell 2 → repeating 100,200,300 with sweep_done every 6 cycles. abort mid-point → next cycle dds_en=0, fword=0, busy=0, no sweep_done. A second start while busy is ignored.
- Reset mid-sweep: assert rst_n low during point 2 → all outputs 0 immediately (async). After release, the block stays IDLE until start.
- Triangle (macro on): 100→300 step 100 dwell 2 → 100,200,300,200,100, each 2 cycles. A single sweep_done after 10 cycles.
